// File: rtl/logic_analyzer_capture.sv
// rtl/logic_analyzer_capture.sv - four-channel triggered sample capture into a circular buffer
// Fills a DEPTH-entry ring around an edge trigger, then freezes it for trigger-aligned reads.
module logic_analyzer_capture #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [3:0]       in_i,
    input  logic             arm_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             trig_en_i,
    input  logic [1:0]       trig_ch_i,
    input  logic             trig_rise_i,
    input  logic [AW-1:0]    pretrig_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [3:0]       rd_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             triggered_o
);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

    state_t           state_q;
    logic [3:0]       in_m_q, in_s_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [AW-1:0]    wr_ptr_q, start_ptr_q, pre_cnt_q, post_cnt_q, pretrig_l_q;
    logic [3:0]       prev_q;
    logic             prev_valid_q;
    logic             busy_q, done_q, triggered_q;
    logic [3:0]       rd_data_q;
    logic [3:0]       mem_q [DEPTH];

    logic             strobe, capturing, wr_en, cur_bit, prv_bit, edge_hit, trig_hit;
    logic [AW-1:0]    rd_ptr, pre_cnt_inc, post_init;

    // arm restarts the interval, so a coincident compare is not a strobe
    assign strobe      = (div_cnt_q == div_i) && !arm_i;
    assign capturing   = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
    assign wr_en       = strobe && capturing && !reset_i;
    assign cur_bit     = in_s_q[trig_ch_i];
    assign prv_bit     = prev_q[trig_ch_i];
    assign edge_hit    = prev_valid_q && (trig_rise_i ? (!prv_bit && cur_bit) : (prv_bit && !cur_bit));
    assign trig_hit    = !trig_en_i || edge_hit;
    assign rd_ptr      = start_ptr_q + rd_addr_i;
    assign pre_cnt_inc = pre_cnt_q + AW'(1);
    assign post_init   = AW'(DEPTH - 1) - pretrig_l_q;

    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (arm_i || (div_cnt_q == div_i)) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_s_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            in_m_q       <= '0;
            in_s_q       <= '0;
            div_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            start_ptr_q  <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            pretrig_l_q  <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            triggered_q  <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            in_m_q    <= in_i;
            in_s_q    <= in_m_q;
            div_cnt_q <= div_cnt_d;
            rd_data_q <= mem_q[rd_ptr];
            if (arm_i) begin
                pretrig_l_q  <= pretrig_i;
                pre_cnt_q    <= '0;
                prev_valid_q <= 1'b0;
                triggered_q  <= 1'b0;
                busy_q       <= 1'b1;
                done_q       <= 1'b0;
                state_q      <= (pretrig_i == '0) ? S_WAIT : S_PRE;
            end else if (strobe && capturing) begin
                wr_ptr_q     <= wr_ptr_q + AW'(1);
                prev_q       <= in_s_q;
                prev_valid_q <= 1'b1;
                case (state_q)
                    S_PRE: begin
                        pre_cnt_q <= pre_cnt_inc;
                        if (pre_cnt_inc == pretrig_l_q) begin
                            state_q <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (trig_hit) begin
                            // pre-increment pointer is the trigger sample's slot
                            start_ptr_q <= wr_ptr_q - pretrig_l_q;
                            triggered_q <= 1'b1;
                            post_cnt_q  <= post_init;
                            if (post_init == '0) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        post_cnt_q <= post_cnt_q - AW'(1);
                        if (post_cnt_q == AW'(1)) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign rd_data_o   = rd_data_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign triggered_o = triggered_q;

endmodule

// File: tb/tb_logic_analyzer_capture.sv
// tb/tb_logic_analyzer_capture.sv - randomized bench for logic_analyzer_capture against a sample-list model
module tb_logic_analyzer_capture;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_v, arm_v, trig_en_v, trig_rise_v;
    logic [3:0]  in_v;
    logic [15:0] div_v;
    logic [1:0]  trig_ch_v;
    logic [8:0]  pretrig_v, rd_addr_v;
    logic [3:0]  rd_data_o;
    logic        busy_o, done_o, triggered_o;

    logic_analyzer_capture #(.DEPTH(512), .AW(9), .DIV_W(16)) dut (
        .clk_i(clk), .reset_i(reset_v), .in_i(in_v), .arm_i(arm_v), .div_i(div_v),
        .trig_en_i(trig_en_v), .trig_ch_i(trig_ch_v), .trig_rise_i(trig_rise_v),
        .pretrig_i(pretrig_v), .rd_addr_i(rd_addr_v), .rd_data_o(rd_data_o),
        .busy_o(busy_o), .done_o(done_o), .triggered_o(triggered_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // hist[e] is the probe value present at rising edge number e
    bit [3:0] hist [0:131071];
    int gen_mode = 1, gen_ch = 0, gen_t1 = 0, gen_t2 = 0;

    always @(negedge clk) begin
        int e;
        logic [3:0] v;
        e = edge_cnt + 1;
        v = 4'($urandom);
        case (gen_mode)
            0: v = 4'(e);
            2: v[gen_ch] = (e >= gen_t1) && (e < gen_t2);
            3: v = 4'd0;
            default: begin end
        endcase
        in_v    = v;
        hist[e] = v;
    end

    int a, cfg_div, cfg_p, cfg_en, cfg_ch, cfg_rise, done_edge;
    logic [3:0] got_buf [DEPTH];

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // sample n of the current capture: strobe n+1 lands div+1 cycles apart, seeing the input from 2 edges earlier
    function automatic int samp(input int n);
        return int'(hist[a + (n + 1) * (cfg_div + 1) - 2]);
    endfunction

    task automatic arm_capture(input int d, input int p, input int en, input int ch, input int rise);
        @(negedge clk);
        cfg_div = d; cfg_p = p; cfg_en = en; cfg_ch = ch; cfg_rise = rise;
        div_v = 16'(d); pretrig_v = 9'(p); trig_en_v = 1'(en); trig_ch_v = 2'(ch); trig_rise_v = 1'(rise);
        a = edge_cnt + 1;
        arm_v = 1'b1;
        @(negedge clk);
        arm_v = 1'b0;
        check_val("busy_after_arm", int'(busy_o), 1);
        check_val("done_after_arm", int'(done_o), 0);
    endtask

    task automatic wait_until(input int target);
        while (edge_cnt < target - 2) @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_o !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        done_edge = edge_cnt;
        check_val("done_reached", int'(done_o), 1);
        check_val("busy_at_done", int'(busy_o), 0);
    endtask

    task automatic verify(input string name);
        int k, writes, prv, cur;
        bit hit;
        k = -1;
        for (int n = cfg_p; n < 20000 && k < 0; n++) begin
            hit = (cfg_en == 0);
            if (!hit && n >= 1) begin
                prv = (samp(n - 1) >> cfg_ch) & 1;
                cur = (samp(n) >> cfg_ch) & 1;
                hit = cfg_rise != 0 ? (prv == 0 && cur == 1) : (prv == 1 && cur == 0);
            end
            if (hit) k = n;
        end
        if (k < 0) begin
            check_val({name, "_model_trigger_found"}, 0, 1);
            return;
        end
        writes = k + DEPTH - cfg_p;
        check_val({name, "_done_edge"}, done_edge, a + writes * (cfg_div + 1));
        check_val({name, "_triggered"}, int'(triggered_o), 1);
        for (int i = 0; i <= DEPTH; i++) begin
            @(negedge clk);
            if (i > 0) begin
                got_buf[i - 1] = rd_data_o;
                check_val($sformatf("%s_rd%0d", name, i - 1), int'(rd_data_o), samp(k - cfg_p + i - 1));
            end
            if (i < DEPTH) rd_addr_v = 9'(i);
        end
        check_val({name, "_done_frozen"}, int'(done_o), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d, p;
        reset_v = 1'b1; arm_v = 1'b0; div_v = '0; trig_en_v = 1'b0; trig_ch_v = '0;
        trig_rise_v = 1'b1; pretrig_v = '0; rd_addr_v = '0;
        repeat (4) @(negedge clk);
        check_val("rst_busy", int'(busy_o), 0);
        check_val("rst_done", int'(done_o), 0);
        check_val("rst_triggered", int'(triggered_o), 0);
        check_val("rst_rd_data", int'(rd_data_o), 0);
        reset_v = 1'b0;

        gen_mode = 0;
        arm_capture(0, 0, 0, 0, 1);
        wait_done(5000);
        verify("full");

        gen_mode = 2; gen_ch = 2; gen_t1 = edge_cnt + 2 + 700 * 4; gen_t2 = 1 << 30;
        arm_capture(3, 100, 1, 2, 1);
        wait_done(20000);
        verify("rise");
        check_val("rise_l99_bit2", int'(got_buf[99][2]), 0);
        check_val("rise_l100_bit2", int'(got_buf[100][2]), 1);
        check_val("rise_l511_bit2", int'(got_buf[511][2]), 1);

        gen_mode = 2; gen_ch = 0; gen_t1 = edge_cnt + 2 + 300 * 2; gen_t2 = gen_t1 + 20;
        arm_capture(1, 50, 1, 0, 0);
        repeat (400) @(negedge clk);
        check_val("fall_no_early_trig", int'(triggered_o), 0);
        wait_done(20000);
        verify("fall");
        check_val("fall_trig_bit0", int'(got_buf[50][0]), 0);
        check_val("fall_pre_bit0", int'(got_buf[49][0]), 1);

        gen_mode = 1;
        arm_capture(0, 511, 1, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
        wait_done(20000);
        verify("p511");

        arm_capture(0, 0, 1, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
        wait_done(20000);
        verify("p0");

        // re-arm exactly on the strobe carrying POST sample 200
        arm_capture(1, 64, 0, 0, 1);
        wait_until(a + 265 * 2);
        check_val("abort_trig_before", int'(triggered_o), 1);
        arm_capture(1, 30, 0, 0, 1);
        check_val("abort_trig_cleared", int'(triggered_o), 0);
        wait_done(20000);
        verify("abort");

        gen_mode = 3;
        arm_capture(0, 10, 1, 0, 1);
        repeat (100) @(negedge clk);
        check_val("wait_busy", int'(busy_o), 1);
        reset_v = 1'b1;
        @(negedge clk);
        reset_v = 1'b0;
        check_val("midrst_busy", int'(busy_o), 0);
        check_val("midrst_done", int'(done_o), 0);
        check_val("midrst_triggered", int'(triggered_o), 0);
        repeat (600) @(negedge clk);
        check_val("idle_busy", int'(busy_o), 0);
        check_val("idle_done", int'(done_o), 0);
        reset_v = 1'b1; arm_v = 1'b1;
        @(negedge clk);
        reset_v = 1'b0; arm_v = 1'b0;
        check_val("rst_over_arm_busy", int'(busy_o), 0);

        gen_mode = 1;
        arm_capture(9, 0, 0, 0, 1);
        wait_done(8000);
        verify("div9");

        for (int t = 0; t < 4; t++) begin
            d = int'($urandom_range(0, 3));
            p = int'($urandom_range(0, 511));
            arm_capture(d, p, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
            wait_done(20000);
            verify($sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
